// File: rtl/hex_history_display.sv
// rtl/hex_history_display.sv - four-digit hex capture history on a multiplexed seven-segment display
module hex_history_display #(
  parameter int SCAN_DIVIDE = 4
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Capture,
  input  logic [3:0] CounterValue,
  input  logic       Freeze,
  output logic [6:0] Segments,
  output logic [3:0] DigitSel,
  output logic [3:0] HistoryValid,
  output logic       WrapPulse
);

  localparam logic [15:0] PRESCALE_LAST = 16'(SCAN_DIVIDE - 1);

  logic [3:0]  digit [4];
  logic [15:0] prescaler;
  logic [1:0]  scan_index;
  logic [3:0]  current_digit;
  logic        capture_accepted;

  assign capture_accepted = Capture && !Freeze;

  // Scan timing: the prescaler paces the digit index independently of captures
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      prescaler  <= 16'd0;
      scan_index <= 2'd0;
    end else if (prescaler == PRESCALE_LAST) begin
      prescaler  <= 16'd0;
      scan_index <= scan_index + 2'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // History shift register; wrap is judged against the pre-capture newest digit
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      digit[0]     <= 4'h0;
      digit[1]     <= 4'h0;
      digit[2]     <= 4'h0;
      digit[3]     <= 4'h0;
      HistoryValid <= 4'b0000;
      WrapPulse    <= 1'b0;
    end else begin
      WrapPulse <= 1'b0;
      if (capture_accepted) begin
        digit[3]     <= digit[2];
        digit[2]     <= digit[1];
        digit[1]     <= digit[0];
        digit[0]     <= CounterValue;
        HistoryValid <= {HistoryValid[2:0], 1'b1};
        WrapPulse    <= (CounterValue == 4'h0) && (digit[0] == 4'hF) && HistoryValid[0];
      end
    end
  end

  // Display decode: digit enable and glyph follow registered state with no extra stage
  always_comb begin
    current_digit = digit[scan_index];
    DigitSel      = ~(4'b0001 << scan_index);
    Segments      = 7'h7F;
    if (HistoryValid[scan_index]) begin
      case (current_digit)
        4'h0:    Segments = 7'h40;
        4'h1:    Segments = 7'h79;
        4'h2:    Segments = 7'h24;
        4'h3:    Segments = 7'h30;
        4'h4:    Segments = 7'h19;
        4'h5:    Segments = 7'h12;
        4'h6:    Segments = 7'h02;
        4'h7:    Segments = 7'h78;
        4'h8:    Segments = 7'h00;
        4'h9:    Segments = 7'h10;
        4'hA:    Segments = 7'h08;
        4'hB:    Segments = 7'h03;
        4'hC:    Segments = 7'h46;
        4'hD:    Segments = 7'h21;
        4'hE:    Segments = 7'h06;
        default: Segments = 7'h0E;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_history_display.sv
// tb/tb_hex_history_display.sv - scoreboard bench for hex_history_display
module tb_hex_history_display;

  logic       ClockIn;
  logic       Reset;
  logic       Capture;
  logic [3:0] CounterValue;
  logic       Freeze;
  logic [6:0] seg4, seg1;
  logic [3:0] dsel4, dsel1;
  logic [3:0] hv4, hv1;
  logic       wrap4, wrap1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         tag;
    bit         which;
    logic [3:0] mask;
    logic [6:0] seg;
    logic [3:0] dsel;
    logic [3:0] hv;
    logic       wr;
    string      name;
  } exp_t;

  exp_t sb[$];

  hex_history_display #(.SCAN_DIVIDE(4)) dut4 (
    .ClockIn(ClockIn), .Reset(Reset), .Capture(Capture), .CounterValue(CounterValue),
    .Freeze(Freeze), .Segments(seg4), .DigitSel(dsel4), .HistoryValid(hv4), .WrapPulse(wrap4)
  );

  hex_history_display #(.SCAN_DIVIDE(1)) dut1 (
    .ClockIn(ClockIn), .Reset(Reset), .Capture(Capture), .CounterValue(CounterValue),
    .Freeze(Freeze), .Segments(seg1), .DigitSel(dsel1), .HistoryValid(hv1), .WrapPulse(wrap1)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  always @(posedge ClockIn) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle tag has come up
  always @(negedge ClockIn) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      exp_t e;
      logic [6:0] s;
      logic [3:0] d;
      logic [3:0] h;
      logic       w;
      e = sb.pop_front();
      s = e.which ? seg1  : seg4;
      d = e.which ? dsel1 : dsel4;
      h = e.which ? hv1   : hv4;
      w = e.which ? wrap1 : wrap4;
      if (e.tag < cyc) begin
        checks++; failures++;
        $display("FAIL %s missed cycle %0d (now %0d)", e.name, e.tag, cyc);
      end else begin
        if (e.mask[3]) begin
          checks++;
          if (s !== e.seg) begin
            failures++;
            $display("FAIL %s cyc=%0d Segments got=%h want=%h", e.name, cyc, s, e.seg);
          end
        end
        if (e.mask[2]) begin
          checks++;
          if (d !== e.dsel) begin
            failures++;
            $display("FAIL %s cyc=%0d DigitSel got=%b want=%b", e.name, cyc, d, e.dsel);
          end
        end
        if (e.mask[1]) begin
          checks++;
          if (h !== e.hv) begin
            failures++;
            $display("FAIL %s cyc=%0d HistoryValid got=%b want=%b", e.name, cyc, h, e.hv);
          end
        end
        if (e.mask[0]) begin
          checks++;
          if (w !== e.wr) begin
            failures++;
            $display("FAIL %s cyc=%0d WrapPulse got=%b want=%b", e.name, cyc, w, e.wr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic expect_at(input int off, input bit which, input logic [3:0] mask,
                           input logic [6:0] seg, input logic [3:0] dsel,
                           input logic [3:0] hv, input logic wr, input string name);
    exp_t e;
    e.tag = cyc + off; e.which = which; e.mask = mask;
    e.seg = seg; e.dsel = dsel; e.hv = hv; e.wr = wr; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Capture = 1'b0; Freeze = 1'b0; CounterValue = 4'h0;
    step();
    Reset = 1'b0;
  endtask

  task automatic capture_1234();
    Capture = 1'b1;
    CounterValue = 4'h1; step();
    CounterValue = 4'h2; step();
    CounterValue = 4'h3; step();
    CounterValue = 4'h4; step();
    Capture = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Capture = 1'b0; Freeze = 1'b0; CounterValue = 4'h0;
    step(); step();
    // Reset state, blank for four cycles, then index 1; SCAN_DIVIDE=1 steps every cycle
    expect_at(0, 0, 4'hF, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_state");
    expect_at(0, 1, 4'h4, 7'h7F, 4'b1110, 4'b0000, 1'b0, "div1_idx0");
    expect_at(1, 0, 4'hC, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_hold1");
    expect_at(1, 1, 4'h4, 7'h7F, 4'b1101, 4'b0000, 1'b0, "div1_idx1");
    expect_at(2, 0, 4'hC, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_hold2");
    expect_at(2, 1, 4'h4, 7'h7F, 4'b1011, 4'b0000, 1'b0, "div1_idx2");
    expect_at(3, 0, 4'hC, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_hold3");
    expect_at(3, 1, 4'h4, 7'h7F, 4'b0111, 4'b0000, 1'b0, "div1_idx3");
    expect_at(4, 0, 4'hC, 7'h7F, 4'b1101, 4'b0000, 1'b0, "rst_advance");
    expect_at(4, 1, 4'h4, 7'h7F, 4'b1110, 4'b0000, 1'b0, "div1_idx0b");
    Reset = 1'b0;
    wait_drain();

    // Four captures, then the scan shows 3,2,1,4 in index order 1,2,3,0
    do_reset();
    expect_at(1,  0, 4'hF, 7'h79, 4'b1110, 4'b0001, 1'b0, "cap1");
    expect_at(2,  0, 4'hF, 7'h24, 4'b1110, 4'b0011, 1'b0, "cap2");
    expect_at(3,  0, 4'hF, 7'h30, 4'b1110, 4'b0111, 1'b0, "cap3");
    expect_at(4,  0, 4'hF, 7'h30, 4'b1101, 4'b1111, 1'b0, "hist_idx1");
    expect_at(8,  0, 4'hF, 7'h24, 4'b1011, 4'b1111, 1'b0, "hist_idx2");
    expect_at(12, 0, 4'hF, 7'h79, 4'b0111, 4'b1111, 1'b0, "hist_idx3");
    expect_at(16, 0, 4'hF, 7'h19, 4'b1110, 4'b1111, 1'b0, "hist_idx0");
    capture_1234();
    wait_drain();

    // F->0 wraps, twice back to back
    do_reset();
    expect_at(1, 0, 4'hF, 7'h0E, 4'b1110, 4'b0001, 1'b0, "wrap_capF");
    expect_at(2, 0, 4'hF, 7'h40, 4'b1110, 4'b0011, 1'b1, "wrap_pulse1");
    expect_at(3, 0, 4'hF, 7'h0E, 4'b1110, 4'b0111, 1'b0, "wrap_gap");
    expect_at(4, 0, 4'hF, 7'h0E, 4'b1101, 4'b1111, 1'b1, "wrap_pulse2");
    expect_at(5, 0, 4'h1, 7'h00, 4'b0000, 4'b0000, 1'b0, "wrap_end");
    Capture = 1'b1;
    CounterValue = 4'hF; step();
    CounterValue = 4'h0; step();
    CounterValue = 4'hF; step();
    CounterValue = 4'h0; step();
    Capture = 1'b0;
    wait_drain();

    // Zero into empty history is not a wrap
    do_reset();
    expect_at(1, 0, 4'hF, 7'h40, 4'b1110, 4'b0001, 1'b0, "empty_cap0");
    expect_at(2, 0, 4'h1, 7'h00, 4'b0000, 4'b0000, 1'b0, "empty_nowrap");
    Capture = 1'b1; CounterValue = 4'h0; step();
    Capture = 1'b0;
    wait_drain();

    // Frozen captures of 7 change nothing while scanning continues
    do_reset();
    expect_at(5,  0, 4'hF, 7'h30, 4'b1101, 4'b1111, 1'b0, "frz1");
    expect_at(6,  0, 4'hF, 7'h30, 4'b1101, 4'b1111, 1'b0, "frz2");
    expect_at(7,  0, 4'hF, 7'h30, 4'b1101, 4'b1111, 1'b0, "frz3");
    expect_at(8,  0, 4'hF, 7'h24, 4'b1011, 4'b1111, 1'b0, "frz_idx2");
    expect_at(12, 0, 4'hF, 7'h79, 4'b0111, 4'b1111, 1'b0, "frz_idx3");
    expect_at(16, 0, 4'hF, 7'h19, 4'b1110, 4'b1111, 1'b0, "frz_idx0");
    capture_1234();
    Freeze = 1'b1; Capture = 1'b1; CounterValue = 4'h7;
    step(); step(); step();
    Freeze = 1'b0; Capture = 1'b0;
    wait_drain();

    // Reset beats a coincident capture after a full history
    do_reset();
    expect_at(4, 0, 4'hF, 7'h30, 4'b1101, 4'b1111, 1'b0, "pre_rst_full");
    expect_at(5, 0, 4'hF, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_cap");
    expect_at(6, 0, 4'hF, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_cap_hold");
    expect_at(8, 0, 4'hC, 7'h7F, 4'b1110, 4'b0000, 1'b0, "rst_cap_pre3");
    expect_at(9, 0, 4'hC, 7'h7F, 4'b1101, 4'b0000, 1'b0, "rst_cap_adv");
    capture_1234();
    Reset = 1'b1; Capture = 1'b1; CounterValue = 4'h5;
    step();
    Reset = 1'b0; Capture = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_history_display.md
HEX_HISTORY_DISPLAY -- requirements
Module: hex_history_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIVIDE, default 4, which sets the number of ClockIn cycles each digit is displayed (legal range 1..65535).
REQ-002 The block SHALL have port ClockIn, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on ClockIn.
REQ-004 The block SHALL have port Capture, input, 1 bit: single-cycle strobe from the upstream rate divider that marks CounterValue as new.
REQ-005 The block SHALL have port CounterValue, input, 4 bits: the value from the upstream display counter.
REQ-006 The block SHALL have port Freeze, input, 1 bit: while high, captures are ignored.
REQ-007 The block SHALL have port Segments, output, 7 bits: active-low seven-segment drive, bit0=a through bit6=g.
REQ-008 The block SHALL have port DigitSel, output, 4 bits: active-low one-hot digit enable; bit n selects digit n.
REQ-009 The block SHALL have port HistoryValid, output, 4 bits: bit n is high when digit n holds a captured value.
REQ-010 The block SHALL have port WrapPulse, output, 1 bit: one-cycle flag that the counter wrapped from F to 0.

Function
REQ-011 On a cycle with Capture=1, Freeze=0 and Reset=0, the block SHALL shift history: digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=CounterValue.
REQ-012 In the same cycle, HistoryValid SHALL shift as {HistoryValid[2:0],1'b1}; capture-to-register latency is 1 cycle.
REQ-013 When Capture=1 and Freeze=1, the block SHALL leave digit registers and HistoryValid unchanged, SHALL keep scanning, and SHALL NOT assert WrapPulse.
REQ-014 The block SHALL hold a 16-bit scan prescaler counting 0..SCAN_DIVIDE-1.
REQ-015 When the prescaler equals SCAN_DIVIDE-1, the prescaler SHALL return to 0 and a 2-bit scan index SHALL advance 0->1->2->3->0; otherwise the prescaler SHALL increment.
REQ-016 With SCAN_DIVIDE=1, the scan index SHALL advance every cycle.
REQ-017 DigitSel SHALL be the active-low one-hot of the current scan index (index 0 -> 4'b1110), combinationally from registered state.
REQ-018 When HistoryValid[index]=1, Segments SHALL be the hex glyph of digit[index] in the same cycle, with no added pipeline stage.
REQ-019 Glyph encoding (active-low, g..a): 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h A=08h b=03h C=46h d=21h E=06h F=0Eh.
REQ-020 When HistoryValid[index]=0, Segments SHALL be 7Fh (blank), while DigitSel is still driven.
REQ-021 WrapPulse SHALL be registered and high for exactly the one cycle after an accepted capture in which CounterValue=0, pre-capture digit0=F and pre-capture HistoryValid[0]=1; otherwise it SHALL be 0.
REQ-022 Back-to-back captures on consecutive cycles SHALL each be accepted; consecutive wraps SHALL each produce a pulse.
REQ-023 A capture that coincides with a scan-index advance SHALL have both take effect in the same edge, with neither blocking the other.

Reset
REQ-024 When Reset=1, all digit registers SHALL clear to 0, HistoryValid to 0000, the prescaler to 0, the scan index to 0, and WrapPulse to 0.
REQ-025 Reset SHALL have priority over Capture and Freeze; a capture in a reset cycle SHALL be discarded.
REQ-026 After reset, outputs SHALL be Segments=7Fh and DigitSel=1110, and SHALL remain so until the first capture or index advance.
REQ-027 Reset asserted mid-scan or mid-history SHALL take effect on the next edge with no residual state.

Verification
REQ-028 The bench SHALL check: Reset for 2 cycles, SCAN_DIVIDE=4 -> Segments=7Fh and DigitSel=1110 for 4 cycles, then DigitSel=1101.
REQ-029 The bench SHALL check: captures of 1, 2, 3, 4 -> digit0..3 = 4,3,2,1, HistoryValid=1111, and the scan shows glyphs 19h, 30h, 24h, 79h in index order.
REQ-030 The bench SHALL check: capture F then capture 0 -> WrapPulse=1 for exactly the cycle after the second capture; capture 0 into empty history -> WrapPulse stays 0.
REQ-031 The bench SHALL check: Freeze=1 with 3 Capture strobes of value 7 -> history and HistoryValid unchanged, scanning continues, WrapPulse=0.
REQ-032 The bench SHALL check: SCAN_DIVIDE=1 -> DigitSel cycles 1110, 1101, 1011, 0111, 1110 on consecutive cycles.
REQ-033 The bench SHALL check: Reset asserted together with Capture (CounterValue=5) after a full history -> next cycle HistoryValid=0000 and Segments=7Fh.
